// File: rtl/pcihellocore_pio_pkg.sv
// Shared constants for the multi-channel PIO output block.
// Holds the per-channel register offsets used by decode and readback.
package pcihellocore_pio_pkg;

   localparam logic [1:0] OFF_DATA  = 2'd0;
   localparam logic [1:0] OFF_SET   = 2'd1;
   localparam logic [1:0] OFF_CLR   = 2'd2;
   localparam logic [1:0] OFF_TIMER = 2'd3;

endpackage

// File: rtl/pcihellocore_pio_timer.sv
// Per-channel auto-clear down-counter with expiry pulse.
// Ports: clk, reset_n, load_i/load_val_i (TIMER write), count_o, busy_o,
// expire_o (high in the cycle whose closing edge takes the count 1->0).
module pcihellocore_pio_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic [CNT_W-1:0] count_o,
   output logic             busy_o,
   output logic             expire_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != '0) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // A reload in the expiry cycle replaces the countdown, so no clear.
   assign expire_o = (count_q == CNT_W'(1)) && !load_i;
   assign busy_o   = (count_q != '0);
   assign count_o  = count_q;

endmodule

// File: rtl/pcihellocore_pio_out_multi.sv
// Multi-channel Avalon-MM PIO output with DATA/SET/CLR/TIMER per channel.
// Ports: clk, reset_n, address {ch,off}, chipselect, write_n, writedata,
// readdata (comb), out_port, busy. Macro PCIHELLOCORE_PIO_AUTOCLEAR_EN
// enables the per-channel auto-clear timers; without it TIMER reads 0.
module pcihellocore_pio_out_multi
   import pcihellocore_pio_pkg::*;
#(
   parameter int          NUM_CH    = 2,
   parameter int          DATA_W    = 32,
   parameter logic [31:0] RESET_VAL = 32'd0,
   parameter int          CNT_W     = 16,
   localparam int         ADDR_W    = $clog2(NUM_CH) + 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [ADDR_W-1:0]        address,
   input  logic                     chipselect,
   input  logic                     write_n,
   input  logic [31:0]              writedata,
   output logic [31:0]              readdata,
   output logic [NUM_CH*DATA_W-1:0] out_port,
   output logic [NUM_CH-1:0]        busy
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [DATA_W-1:0] RST_D = RESET_VAL[DATA_W-1:0];

   logic              wr;
   logic [1:0]        off;
   logic [31:0]       ch_idx;
   logic              ch_ok;
   logic [CH_W-1:0]   ch_sel;
   logic [DATA_W-1:0] data_all [NUM_CH];
   logic [CNT_W-1:0]  cnt_all  [NUM_CH];
   logic              unused_ok;

   assign wr  = chipselect & ~write_n;
   assign off = address[1:0];

   if (NUM_CH > 1) begin : g_idx
      assign ch_idx = 32'(address[ADDR_W-1:2]);
   end else begin : g_idx1
      assign ch_idx = '0;
   end

   // Non-power-of-two channel counts leave unmapped indices.
   assign ch_ok  = ch_idx < 32'(NUM_CH);
   assign ch_sel = ch_idx[CH_W-1:0];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic              sel;
      logic              expire;
      logic [CNT_W-1:0]  cnt;
      logic [DATA_W-1:0] data_q;
      logic [DATA_W-1:0] data_d;

      assign sel = wr & ch_ok & (ch_sel == CH_W'(c));

`ifdef PCIHELLOCORE_PIO_AUTOCLEAR_EN
      pcihellocore_pio_timer #(
         .CNT_W(CNT_W)
      ) u_timer (
         .clk       (clk),
         .reset_n   (reset_n),
         .load_i    (sel && (off == OFF_TIMER)),
         .load_val_i(writedata[CNT_W-1:0]),
         .count_o   (cnt),
         .busy_o    (busy[c]),
         .expire_o  (expire)
      );
`else
      assign cnt     = '0;
      assign busy[c] = 1'b0;
      assign expire  = 1'b0;
`endif

      // Register writes win over an expiry clear in the same cycle.
      always_comb begin
         data_d = data_q;
         if (sel && (off != OFF_TIMER)) begin
            case (off)
               OFF_DATA: data_d = writedata[DATA_W-1:0];
               OFF_SET:  data_d = data_q | writedata[DATA_W-1:0];
               OFF_CLR:  data_d = data_q & ~writedata[DATA_W-1:0];
               default:  data_d = data_q;
            endcase
         end else if (expire) begin
            data_d = '0;
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            data_q <= RST_D;
         end else begin
            data_q <= data_d;
         end
      end

      assign out_port[c*DATA_W +: DATA_W] = data_q;
      assign data_all[c] = data_q;
      assign cnt_all[c]  = cnt;
   end

   always_comb begin
      readdata = '0;
      if (ch_ok) begin
         case (off)
            OFF_DATA:  readdata = 32'(data_all[ch_sel]);
            OFF_TIMER: readdata = 32'(cnt_all[ch_sel]);
            default:   readdata = '0;
         endcase
      end
   end

   assign unused_ok = ^{writedata, ch_idx};

endmodule

// File: tb/tb_pcihellocore_pio_out_multi.sv
// Directed bench for pcihellocore_pio_out_multi (2 channels x 32 bits).
// Expectations queue on a scoreboard and are checked against DUT outputs.
module tb_pcihellocore_pio_out_multi;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [63:0] out_port;
   logic [1:0]  busy;

   logic [63:0] exp_q [$];
   string       tag_q [$];
   int          n_vec;
   int          n_err;
   logic [31:0] rv;

   pcihellocore_pio_out_multi #(
      .NUM_CH   (2),
      .DATA_W   (32),
      .RESET_VAL(32'd0),
      .CNT_W    (16)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .out_port  (out_port),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input string t, input logic [63:0] e);
      tag_q.push_back(t);
      exp_q.push_back(e);
   endtask

   task automatic pop_chk(input logic [63:0] obs);
      string       t;
      logic [63:0] e;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $error("FAIL sb_empty: observed %0h required none", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", t, obs, e);
         end
      end
   endtask

   // Called at a falling edge; the write lands on the next rising edge.
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      reset_n    = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = '0;
      writedata  = '0;

      repeat (2) @(negedge clk);
      push("rst_out", 64'd0);   pop_chk(out_port);
      push("rst_busy", 64'd0);  pop_chk(64'(busy));
      push("rst_rd0", 64'd0);   rd(3'd0, rv); pop_chk(64'(rv));
      push("rst_rd3", 64'd0);   rd(3'd3, rv); pop_chk(64'(rv));

      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      push("rel_out", 64'd0);   pop_chk(out_port);

      push("wr_hi", 64'hA5A50000);
      push("wr_lo", 64'd0);
      push("wr_rd4", 64'hA5A50000);
      wr(3'd4, 32'hA5A50000);
      pop_chk(64'(out_port[63:32]));
      pop_chk(64'(out_port[31:0]));
      rd(3'd4, rv); pop_chk(64'(rv));

      push("setclr_lo", 64'h000000F0);
      push("setclr_hi", 64'hA5A50000);
      push("rd_set", 64'd0);
      push("rd_clr", 64'd0);
      wr(3'd1, 32'h000000FF);
      wr(3'd2, 32'h0000000F);
      pop_chk(64'(out_port[31:0]));
      pop_chk(64'(out_port[63:32]));
      rd(3'd1, rv); pop_chk(64'(rv));
      rd(3'd2, rv); pop_chk(64'(rv));

`ifdef PCIHELLOCORE_PIO_AUTOCLEAR_EN
      wr(3'd0, 32'hFFFFFFFF);
      wr(3'd3, 32'd3);
      for (int i = 0; i < 3; i++) begin
         push("ac_busy", 64'd1);
         push("ac_cnt", 64'(3 - i));
         push("ac_data", 64'hFFFFFFFF);
         pop_chk(64'(busy));
         rd(3'd3, rv); pop_chk(64'(rv));
         pop_chk(64'(out_port[31:0]));
         @(negedge clk);
      end
      push("ac_cleared", 64'd0);      pop_chk(64'(out_port[31:0]));
      push("ac_busy_off", 64'd0);     pop_chk(64'(busy));
      push("ac_ch1_kept", 64'hA5A50000);
      pop_chk(64'(out_port[63:32]));

      wr(3'd0, 32'hFFFFFFFF);
      wr(3'd3, 32'd2);
      @(negedge clk);
      wr(3'd0, 32'h00001234);
      push("wvx_data", 64'h1234);     pop_chk(64'(out_port[31:0]));
      push("wvx_busy", 64'd0);        pop_chk(64'(busy));

      wr(3'd0, 32'hFFFFFFFF);
      wr(3'd3, 32'd2);
      @(negedge clk);
      wr(3'd3, 32'd5);
      push("tvx_data", 64'hFFFFFFFF); pop_chk(64'(out_port[31:0]));
      push("tvx_cnt", 64'd5);         rd(3'd3, rv); pop_chk(64'(rv));

      wr(3'd3, 32'd0);
      push("cancel_busy", 64'd0);     pop_chk(64'(busy));
      repeat (6) @(negedge clk);
      push("cancel_data", 64'hFFFFFFFF);
      pop_chk(64'(out_port[31:0]));

      wr(3'd3, 32'd4);
      repeat (2) @(negedge clk);
      push("mid_cnt", 64'd2);         rd(3'd3, rv); pop_chk(64'(rv));
      reset_n = 1'b0;
      #1;
      push("mid_busy", 64'd0);        pop_chk(64'(busy));
      push("mid_out", 64'd0);         pop_chk(out_port);
      push("mid_rd3", 64'd0);         rd(3'd3, rv); pop_chk(64'(rv));
      @(negedge clk);
      reset_n = 1'b1;
      wr(3'd0, 32'h0000CAFE);
      repeat (6) @(negedge clk);
      push("mid_noclr", 64'hCAFE);    pop_chk(64'(out_port[31:0]));
      push("mid_busy2", 64'd0);       pop_chk(64'(busy));
`else
      wr(3'd3, 32'd3);
      push("nt_rd3", 64'd0);          rd(3'd3, rv); pop_chk(64'(rv));
      push("nt_busy", 64'd0);         pop_chk(64'(busy));
      repeat (5) @(negedge clk);
      push("nt_data", 64'h000000F0);  pop_chk(64'(out_port[31:0]));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pcihellocore_pio_out_multi.md
PCIHELLOCORE_PIO_OUT_MULTI -- requirements
Module: pcihellocore_pio_out_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning the number of output channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 32, meaning the bits per channel (1..32).
REQ-003 SHALL have parameter RESET_VAL, default 0, meaning the DATA value of every channel after reset.
REQ-004 SHALL have parameter CNT_W, default 16, meaning the auto-clear counter width (1..32).
REQ-005 SHALL have port clk, input, 1 bit: clock.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port address, input, ADDR_W bits, where ADDR_W = clog2(NUM_CH)+2: word address as {channel, offset}.
REQ-008 SHALL have ports chipselect (input, 1), write_n (input, 1, active-low) and writedata (input, 32): Avalon-MM slave write.
REQ-009 SHALL have port readdata, output, 32 bits: combinational read data, readLatency 0.
REQ-010 SHALL have port out_port, output, NUM_CH*DATA_W bits: channel c DATA on bits [c*DATA_W +: DATA_W].
REQ-011 SHALL have port busy, output, NUM_CH bits: bit c is 1 while the channel c auto-clear counter is nonzero.

Function
REQ-012 SHALL decode a write strobe as chipselect & ~write_n; offsets per channel: 0 DATA (RW), 1 SET (WO), 2 CLR (WO), 3 TIMER (RW).
REQ-013 SHALL, on a DATA write, load DATA <= writedata[DATA_W-1:0] at the next clk edge.
REQ-014 SHALL, on a SET write, apply DATA <= DATA | writedata[DATA_W-1:0].
REQ-015 SHALL, on a CLR write, apply DATA <= DATA & ~writedata[DATA_W-1:0].
REQ-016 SHALL drive out_port directly from the DATA registers, with no extra pipeline stage.
REQ-017 SHALL, on a TIMER write of N, load count <= writedata[CNT_W-1:0]; N=0 cancels a running countdown without touching DATA.
REQ-018 SHALL decrement a nonzero count by 1 every cycle; on the edge where the count goes 1->0, channel DATA is cleared to 0, i.e. N cycles after the load edge.
REQ-019 SHALL give precedence to any DATA/SET/CLR write over an expiry clear in the same cycle; the write result is kept and the count still reaches 0.
REQ-020 SHALL give precedence to a TIMER write over an expiry in the same cycle; the new N is loaded and no clear occurs.
REQ-021 SHALL, on a read, return zero-extended DATA for offset 0 and zero-extended count for offset 3; offsets 1 and 2 read 0.
REQ-022 SHALL ignore writes to channel indices >= NUM_CH, and such reads SHALL return 0.
REQ-023 SHALL leave all other channels unaffected by any access to one channel.

Reset
REQ-024 SHALL, while reset_n=0 and independent of clk, force DATA=RESET_VAL, count=0 and busy=0 for all channels, even mid-countdown.
REQ-025 SHALL, after reset release, have out_port = NUM_CH copies of RESET_VAL.

Configuration
REQ-026 SHALL, with PCIHELLOCORE_PIO_AUTOCLEAR_EN defined, implement TIMER and busy as specified above.
REQ-027 SHALL, without PCIHELLOCORE_PIO_AUTOCLEAR_EN, make TIMER read 0 and ignore its writes, tie busy to 0, and synthesize no counters.

Structure
REQ-028 SHALL place the offset constants (OFF_DATA=0, OFF_SET=1, OFF_CLR=2, OFF_TIMER=3) in package pcihellocore_pio_pkg.
REQ-029 SHALL implement the per-channel down-counter and expiry pulse as sub-module pcihellocore_pio_timer, generated NUM_CH times.

Verification (NUM_CH=2, DATA_W=32, RESET_VAL=0, macro defined)
REQ-030 SHALL cover reset: reset_n low -> out_port=0, busy=0, reads at addresses 0 and 3 return 0.
REQ-031 SHALL cover a data write: write 0xA5A50000 to address 4 -> out_port[63:32]=0xA5A50000 next cycle, out_port[31:0]=0, read of address 4 returns 0xA5A50000.
REQ-032 SHALL cover set/clear: ch0 from 0, SET 0x000000FF then CLR 0x0000000F -> out_port[31:0]=0x000000F0.
REQ-033 SHALL cover auto-clear: ch0 DATA=0xFFFFFFFF, TIMER=3 -> busy[0] high 3 cycles, reads of address 3 return 3,2,1, DATA=0 on the 3rd edge after load.
REQ-034 SHALL cover write-vs-expiry: DATA write 0x1234 in the expiry cycle -> DATA=0x1234, busy[0]=0; TIMER write 5 in the expiry cycle -> DATA kept, count=5.
REQ-035 SHALL cover reset mid-countdown: reset_n pulsed low at count=2 -> count=0, busy=0, DATA=0, no later clear event.
